// File: rtl/rf_pkg.sv
// Shared defaults, reset value and address qualification for the parameterised register file.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  localparam logic [RF_DATA_W-1:0] RF_RST_VAL = '0;

  // True when addr names a real, writable register (in range, and not a hardwired r0).
  function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned depth,
                                      input bit zero_reg);
    return (addr < depth) && !(zero_reg && addr == 0);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: decode, zero/range masking and (with RF_BYPASS_EN) write bypass.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic [DEPTH-1:0]              pend,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_pend
);

  logic              addr_ok;
  logic [DATA_W-1:0] data_next;
  logic              pend_next;

  always_comb begin
    addr_ok   = rf_addr_ok(32'(rd_addr), DEPTH, ZERO_REG != 0);
    data_next = DATA_W'(RF_RST_VAL);
    pend_next = 1'b0;
    if (addr_ok) begin
      data_next = regs[rd_addr];
      pend_next = pend[rd_addr];
`ifdef RF_BYPASS_EN
      // A matching write is effective here because rd_addr is already known valid.
      if (wr_en && wr_addr == rd_addr) begin
        data_next = wr_data;
        pend_next = rsv_en && (rsv_addr == rd_addr);
      end
`endif
    end
  end

`ifndef RF_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_en, wr_addr, wr_data, rsv_en, rsv_addr};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= DATA_W'(RF_RST_VAL);
      rd_pend <= 1'b0;
    end else begin
      rd_data <= data_next;
      rd_pend <= pend_next;
    end
  end

endmodule

// File: rtl/param_register_file.sv
// Multi-read-port register file with per-register pending (scoreboard) bits.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module param_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend
);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend;
  logic                         wr_ok;
  logic                         rsv_ok;

  assign wr_ok  = wr_en  && rf_addr_ok(32'(wr_addr),  DEPTH, ZERO_REG != 0);
  assign rsv_ok = rsv_en && rf_addr_ok(32'(rsv_addr), DEPTH, ZERO_REG != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= {DEPTH{DATA_W'(RF_RST_VAL)}};
      pend <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      // Placed after the clear so a same-cycle reservation of the written register wins.
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .regs    (regs),
      .pend    (pend),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
      .rd_addr (rd_addr[gi*ADDR_W +: ADDR_W]),
      .rd_data (rd_data[gi*DATA_W +: DATA_W]),
      .rd_pend (rd_pend[gi])
    );
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: default-configuration instance plus a DATA_W=16/DEPTH=24/NUM_RD=3 instance.
module tb_param_register_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DATA_W=32, DEPTH=32, NUM_RD=2
  logic        a_wr_en, a_rsv_en;
  logic [4:0]  a_wr_addr, a_rsv_addr;
  logic [31:0] a_wr_data;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_pend;

  // Swept instance: DATA_W=16, DEPTH=24, NUM_RD=3
  logic        b_wr_en, b_rsv_en;
  logic [4:0]  b_wr_addr, b_rsv_addr;
  logic [15:0] b_wr_data;
  logic [14:0] b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_pend;

  int n_tests = 0;
  int n_fail  = 0;

  param_register_file u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pend(a_rd_pend)
  );

  param_register_file #(.DATA_W(16), .DEPTH(24), .NUM_RD(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pend(b_rd_pend)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_rsv_en = 0; a_rsv_addr = 0; a_rd_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rsv_en = 0; b_rsv_addr = 0; b_rd_addr = 0;

    // Reset state
    step(); step();
    chk("reset_a_data", a_rd_data, 64'h0);
    chk("reset_a_pend", a_rd_pend, 64'h0);
    chk("reset_b_data", b_rd_data, 64'h0);
    rst_n = 1'b1;
    step();

    // Mid-run reset after writing and reserving r5
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF;
    step();
    a_wr_en = 0; a_rsv_en = 1; a_rsv_addr = 5; a_rd_addr = {5'd0, 5'd5};
    step();
    chk("r5_before_reset", a_rd_data[31:0], 64'hDEADBEEF);
    a_rsv_en = 0;
    step();
    chk("r5_pend_before_reset", a_rd_pend[0], 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_data", a_rd_data, 64'h0);
    chk("async_reset_pend", a_rd_pend, 64'h0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("r5_after_reset", a_rd_data[31:0], 64'h0);
    chk("r5_pend_after_reset", a_rd_pend[0], 64'h0);

    // Write r9, read on both ports
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'd41;
    step();
    a_wr_en = 0; a_rd_addr = {5'd9, 5'd9};
    step();
    chk("r9_port0", a_rd_data[31:0], 64'd41);
    chk("r9_port1", a_rd_data[63:32], 64'd41);
    chk("r9_pend_both", a_rd_pend, 64'h0);

    // Hardwired zero register
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'h1234; a_rsv_en = 1; a_rsv_addr = 0;
    step();
    a_wr_en = 0; a_rsv_en = 0; a_rd_addr = {5'd0, 5'd0};
    step();
    chk("r0_data", a_rd_data[31:0], 64'h0);
    chk("r0_pend", a_rd_pend[0], 64'h0);

    // Scoreboard: reserve r20, then write it; same-cycle rsv+write of r21
    a_rsv_en = 1; a_rsv_addr = 20; a_rd_addr = {5'd21, 5'd20};
    step();
    a_rsv_en = 0;
    step();
    chk("r20_pend_set", a_rd_pend[0], 64'h1);
    a_wr_en = 1; a_wr_addr = 20; a_wr_data = 32'd15;
    step();
    a_wr_en = 0;
    step();
    chk("r20_data", a_rd_data[31:0], 64'd15);
    chk("r20_pend_clr", a_rd_pend[0], 64'h0);
    a_wr_en = 1; a_wr_addr = 21; a_wr_data = 32'd40; a_rsv_en = 1; a_rsv_addr = 21;
    step();
    a_wr_en = 0; a_rsv_en = 0;
    step();
    chk("r21_data", a_rd_data[63:32], 64'd40);
    chk("r21_pend_kept", a_rd_pend[1], 64'h1);

    // Same-cycle write and read of r16 (old value 7)
    a_wr_en = 1; a_wr_addr = 16; a_wr_data = 32'd7;
    step();
    a_wr_en = 0; a_rd_addr = {5'd21, 5'd16};
    step();
    a_wr_en = 1; a_wr_addr = 16; a_wr_data = 32'd232;
    step();
`ifdef RF_BYPASS_EN
    chk("r16_same_cycle", a_rd_data[31:0], 64'd232);
`else
    chk("r16_same_cycle", a_rd_data[31:0], 64'd7);
`endif
    a_wr_en = 0;
    step();
    chk("r16_next_cycle", a_rd_data[31:0], 64'd232);

    // Same-cycle write and read of a reserved r17: pending flag follows the data path
    a_rsv_en = 1; a_rsv_addr = 17;
    step();
    a_rsv_en = 0; a_rd_addr = {5'd17, 5'd16};
    a_wr_en = 1; a_wr_addr = 17; a_wr_data = 32'd99;
    step();
`ifdef RF_BYPASS_EN
    chk("r17_same_data", a_rd_data[63:32], 64'd99);
    chk("r17_same_pend", a_rd_pend[1], 64'h0);
`else
    chk("r17_same_data", a_rd_data[63:32], 64'd0);
    chk("r17_same_pend", a_rd_pend[1], 64'h1);
`endif
    a_wr_en = 0;
    step();
    chk("r17_next_data", a_rd_data[63:32], 64'd99);
    chk("r17_next_pend", a_rd_pend[1], 64'h0);

    // Parameter sweep: DEPTH=24, out-of-range accesses discarded
    b_wr_en = 1; b_wr_addr = 23; b_wr_data = 16'hBEEF;
    step();
    b_wr_addr = 30; b_wr_data = 16'h1111; b_rsv_en = 1; b_rsv_addr = 30;
    step();
    b_wr_en = 0; b_rsv_en = 0; b_rd_addr = {5'd24, 5'd30, 5'd23};
    step();
    chk("b_r23", b_rd_data[15:0], 64'hBEEF);
    chk("b_a30_data", b_rd_data[31:16], 64'h0);
    chk("b_a30_pend", b_rd_pend[1], 64'h0);
    chk("b_a24_data", b_rd_data[47:32], 64'h0);
    b_rd_addr = {5'd6, 5'd23, 5'd23};
    step();
    chk("b_r23_port1", b_rd_data[31:16], 64'hBEEF);
    chk("b_r6_untouched", b_rd_data[47:32], 64'h0);
    chk("b_pend_all", b_rd_pend, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
